// File: rtl/dct_coef_collector.sv
// Collects CORDIC (x2,y2) pairs of an 8-point DCT block, normalises each word and streams
// the coefficients out in natural order through a two-bank ping-pong buffer.
module dct_coef_collector #(
   parameter int unsigned M        = 23,
   parameter int unsigned E        = 8,
   parameter int unsigned LAT      = 16,
   parameter int unsigned SCALE_SH = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [M+E:0] x2,
   input  logic [M+E:0] y2,
   output logic [M+E:0] out_data,
   output logic [2:0]   out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         overflow,
   output logic         busy
);

   localparam int unsigned W = M + E + 1;
   localparam logic [E-1:0] ExpMax = '1;
   localparam logic [E-1:0] ExpSh  = E'(SCALE_SH);

   typedef enum logic [0:0] {StIdle, StDrain} state_t;

   // Inf/NaN pass through; anything that would underflow becomes a signed zero.
   function automatic logic [W-1:0] norm(input logic [W-1:0] w);
      logic [E-1:0] ex;
      ex = w[W-2:M];
      if (ex == ExpMax) begin
         norm = w;
      end else if (ex <= ExpSh) begin
         norm = {w[W-1], {(W-1){1'b0}}};
      end else begin
         norm = {w[W-1], ex - ExpSh, w[M-1:0]};
      end
   endfunction

   function automatic logic [2:0] x_addr(input logic [1:0] k);
      unique case (k)
         2'd0:    x_addr = 3'd0;
         2'd1:    x_addr = 3'd2;
         2'd2:    x_addr = 3'd1;
         default: x_addr = 3'd5;
      endcase
   endfunction

   function automatic logic [2:0] y_addr(input logic [1:0] k);
      unique case (k)
         2'd0:    y_addr = 3'd4;
         2'd1:    y_addr = 3'd6;
         2'd2:    y_addr = 3'd7;
         default: y_addr = 3'd3;
      endcase
   endfunction

   logic [LAT-1:0] vdly_q;
   logic [1:0]     k_q;
   logic           wr_q;
   logic           rd_q;
   logic [1:0]     full_q;
   logic [1:0]     full_d;
   logic           ovf_q;
   logic [W-1:0]   mem [16];

   state_t         st_q;
   logic           ov_q;
   logic           last_q;
   logic [2:0]     idx_q;
   logic [2:0]     idx_nxt;
   logic [W-1:0]   data_q;

   logic           res_v;
   logic           accept;
   logic           drop;
   logic           set_full;
   logic           drain_done;

   assign res_v      = vdly_q[LAT-1];
   assign drop       = res_v && (k_q == 2'd0) && full_q[wr_q];
   assign accept     = res_v && !drop;
   assign set_full   = accept && (k_q == 2'd3);
   assign drain_done = (st_q == StDrain) && out_ready && (idx_q == 3'd7);
   assign idx_nxt    = idx_q + 3'd1;

   // Writes only target a non-full bank and drains only a full one, so the two never collide.
   always_comb begin
      full_d = full_q;
      if (set_full) begin
         full_d[wr_q] = 1'b1;
      end
      if (drain_done) begin
         full_d[rd_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         vdly_q <= '0;
         k_q    <= 2'd0;
         wr_q   <= 1'b0;
         full_q <= 2'b00;
         ovf_q  <= 1'b0;
      end else begin
         vdly_q <= {vdly_q[LAT-2:0], in_valid};
         full_q <= full_d;
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (accept) begin
            k_q <= k_q + 2'd1;
         end
         if (set_full) begin
            wr_q <= ~wr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[{wr_q, x_addr(k_q)}] <= norm(x2);
         mem[{wr_q, y_addr(k_q)}] <= norm(y2);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         st_q   <= StIdle;
         rd_q   <= 1'b0;
         ov_q   <= 1'b0;
         last_q <= 1'b0;
         idx_q  <= 3'd0;
         data_q <= '0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (full_q[rd_q]) begin
                  st_q   <= StDrain;
                  ov_q   <= 1'b1;
                  idx_q  <= 3'd0;
                  last_q <= 1'b0;
                  data_q <= mem[{rd_q, 3'd0}];
               end
            end
            StDrain: begin
               if (out_ready) begin
                  if (idx_q == 3'd7) begin
                     rd_q   <= ~rd_q;
                     idx_q  <= 3'd0;
                     last_q <= 1'b0;
                     // Chain straight into the other bank when it is already waiting.
                     if (full_q[~rd_q]) begin
                        data_q <= mem[{~rd_q, 3'd0}];
                     end else begin
                        st_q <= StIdle;
                        ov_q <= 1'b0;
                     end
                  end else begin
                     idx_q  <= idx_nxt;
                     last_q <= (idx_nxt == 3'd7);
                     data_q <= mem[{rd_q, idx_nxt}];
                  end
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_valid = ov_q;
   assign out_last  = last_q;
   assign overflow  = ovf_q;
   assign busy      = (|vdly_q) | (k_q != 2'd0) | full_q[0] | full_q[1];

endmodule

// File: tb/tb_dct_coef_collector.sv
// Bench for dct_coef_collector: a block-level model predicts every output beat, its
// earliest visible cycle, overflow and busy; directed tests pin literal values.
module tb_dct_coef_collector;

   localparam int LAT = 16;
   localparam int SH  = 1;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  idx;
      logic        last;
      int          avail;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  idx;
      logic        last;
      int          cyc;
   } obs_t;

   typedef struct {
      int          t;
      logic [31:0] x;
      logic [31:0] y;
   } res_t;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_valid;
   logic [31:0] x2;
   logic [31:0] y2;
   logic [31:0] out_data;
   logic [2:0]  out_idx;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        overflow;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit toggle_rdy = 0;

   beat_t exp_q[$];
   obs_t  log_q[$];
   res_t  emu_q[$];
   int    sched[$];
   int    kpos = 0;
   int    pend = 0;
   logic  ovf_m = 1'b0;
   logic [31:0] blk [8];
   int xmap [4] = '{0, 2, 1, 5};
   int ymap [4] = '{4, 6, 7, 3};

   dct_coef_collector dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .x2        (x2),
      .y2        (y2),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Multiplying by 2^-SH on the value: lower the exponent field, flushing tiny values.
   function automatic logic [31:0] mnorm(input logic [31:0] w);
      int e;
      e = int'(w[30:23]);
      if (e == 255) return w;
      if (e <= SH) return w & 32'h8000_0000;
      return w - (32'(SH) << 23);
   endfunction

   // CORDIC stand-in: results appear on x2/y2 only in their cycle, junk otherwise.
   initial forever begin
      @(posedge clk);
      #1;
      if (emu_q.size() > 0 && emu_q[0].t == cyc) begin
         x2 = emu_q[0].x;
         y2 = emu_q[0].y;
         void'(emu_q.pop_front());
      end else begin
         x2 = $urandom;
         y2 = $urandom;
      end
   end

   // Model and compare, evaluated mid-cycle for the edge that follows.
   initial forever begin
      @(negedge clk);
      if (!clr) begin
         chk("rst_valid", {63'd0, out_valid}, 64'd0);
         chk("rst_data", {32'd0, out_data}, 64'd0);
         chk("rst_ovf", {63'd0, overflow}, 64'd0);
         chk("rst_busy", {63'd0, busy}, 64'd0);
         exp_q.delete();
         sched.delete();
         kpos  = 0;
         pend  = 0;
         ovf_m = 1'b0;
      end else begin
         logic exp_v;
         logic exp_busy;
         exp_v = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
         chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
         if (out_valid && exp_v) begin
            chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
            chk("out_idx", {61'd0, out_idx}, {61'd0, exp_q[0].idx});
            chk("out_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
         end
         exp_busy = (sched.size() > 0) || (kpos != 0) || (pend != 0);
         chk("overflow", {63'd0, overflow}, {63'd0, ovf_m});
         chk("busy", {63'd0, busy}, {63'd0, exp_busy});

         if (in_valid) sched.push_back(cyc + LAT);
         if (sched.size() > 0 && sched[0] == cyc) begin
            void'(sched.pop_front());
            if (kpos == 0 && pend == 2) begin
               ovf_m = 1'b1;
            end else begin
               blk[xmap[kpos]] = mnorm(x2);
               blk[ymap[kpos]] = mnorm(y2);
               kpos++;
               if (kpos == 4) begin
                  kpos = 0;
                  pend++;
                  for (int i = 0; i < 8; i++) begin
                     exp_q.push_back('{data: blk[i], idx: 3'(i), last: (i == 7), avail: cyc + 2});
                  end
               end
            end
         end
         if (out_valid && exp_v && out_ready) begin
            beat_t b;
            b = exp_q.pop_front();
            log_q.push_back('{data: out_data, idx: out_idx, last: out_last, cyc: cyc});
            if (b.last) pend--;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (toggle_rdy) out_ready = ~out_ready;
      end
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      in_valid = 1'b1;
      emu_q.push_back('{t: cyc + LAT, x: x, y: y});
      step(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_beats(input string name, input int target, input int budget);
      int i;
      i = 0;
      while (log_q.size() < target && i < budget) begin
         step(1);
         i++;
      end
      chk(name, 64'(log_q.size()), 64'(target));
   endtask

   initial begin
      int base;
      int i;
      clr       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("async_rst_last", {63'd0, out_last}, 64'd0);
      chk("async_rst_idx", {61'd0, out_idx}, 64'd0);
      chk("async_rst_busy", {63'd0, busy}, 64'd0);

      chk("lit_norm_min", {32'd0, mnorm(32'h0080_0000)}, 64'h0000_0000);
      chk("lit_norm_negmin", {32'd0, mnorm(32'h8080_0000)}, 64'h8000_0000);
      chk("lit_norm_inf", {32'd0, mnorm(32'h7F80_0000)}, 64'h7F80_0000);
      chk("lit_norm_nan", {32'd0, mnorm(32'h7FC0_0000)}, 64'h7FC0_0000);
      chk("lit_norm_ten", {32'd0, mnorm(32'h4120_0000)}, 64'h40A0_0000);

      step(3);
      clr = 1'b1;
      step(2);

      // T1: one block, natural-order output
      base = log_q.size();
      issue(32'h3F80_0000, 32'h4000_0000);
      issue(32'h4040_0000, 32'h4080_0000);
      issue(32'hC000_0000, 32'h3E80_0000);
      issue(32'h0000_0000, 32'h7F80_0000);
      wait_beats("t1_beats", base + 8, 60);
      if (log_q.size() >= base + 8) begin
         chk("t1_idx0", {32'd0, log_q[base].data}, 64'h3F00_0000);
         chk("t1_idx4", {32'd0, log_q[base + 4].data}, 64'h3F80_0000);
         for (int j = 0; j < 8; j++) begin
            chk("t1_order", {61'd0, log_q[base + j].idx}, 64'(j));
            chk("t1_lastflag", {63'd0, log_q[base + j].last}, {63'd0, 1'(j == 7)});
         end
      end
      step(3);
      chk("t1_idle_busy", {63'd0, busy}, 64'd0);

      // T2: spaced rotations so neighbouring cycles carry junk
      base = log_q.size();
      issue(32'h3F80_0000, 32'h3F80_0000);
      step(3);
      issue(32'h4000_0000, 32'hC000_0000);
      step(3);
      issue(32'h4100_0000, 32'h4110_0000);
      step(2);
      issue(32'h4220_0000, 32'h4230_0000);
      wait_beats("t2_beats", base + 8, 60);
      if (log_q.size() >= base + 8) begin
         chk("t2_idx0", {32'd0, log_q[base].data}, 64'h3F00_0000);
         chk("t2_idx6", {32'd0, log_q[base + 6].data}, 64'hBF80_0000);
      end

      // T3: edge words, drained with a stalling consumer
      base = log_q.size();
      issue(32'h0080_0000, 32'h8080_0000);
      issue(32'h7F80_0000, 32'h7FC0_0000);
      issue(32'h4120_0000, 32'h0000_0000);
      issue(32'h3F80_0001, 32'hBF80_0000);
      toggle_rdy = 1;
      wait_beats("t3_beats", base + 8, 80);
      toggle_rdy = 0;
      out_ready  = 1'b1;
      if (log_q.size() >= base + 8) begin
         chk("t3_idx0", {32'd0, log_q[base].data}, 64'h0000_0000);
         chk("t3_idx4", {32'd0, log_q[base + 4].data}, 64'h8000_0000);
         chk("t3_idx2", {32'd0, log_q[base + 2].data}, 64'h7F80_0000);
         chk("t3_idx6", {32'd0, log_q[base + 6].data}, 64'h7FC0_0000);
         chk("t3_idx1", {32'd0, log_q[base + 1].data}, 64'h40A0_0000);
      end
      step(3);

      // T5: two back-to-back blocks, contiguous output
      base = log_q.size();
      for (int j = 0; j < 8; j++) begin
         issue(32'h3F80_0000 + 32'(j << 23), 32'hBF80_0000 + 32'(j));
      end
      wait_beats("t5_beats", base + 16, 80);
      if (log_q.size() >= base + 16) begin
         for (int j = 1; j < 16; j++) begin
            chk("t5_contig", 64'(log_q[base + j].cyc - log_q[base + j - 1].cyc), 64'd1);
         end
         chk("t5_last8", {63'd0, log_q[base + 7].last}, 64'd1);
         chk("t5_last16", {63'd0, log_q[base + 15].last}, 64'd1);
      end
      step(3);

      // T4: consumer stalled, third block overflows
      base = log_q.size();
      out_ready = 1'b0;
      for (int j = 0; j < 12; j++) begin
         issue(32'h4000_0000 + 32'(j), 32'h4080_0000 + 32'(j));
      end
      step(LAT + 6);
      chk("t4_overflow", {63'd0, overflow}, 64'd1);
      chk("t4_busy", {63'd0, busy}, 64'd1);
      chk("t4_nobeats", 64'(log_q.size()), 64'(base));
      out_ready = 1'b1;
      wait_beats("t4_beats", base + 16, 60);
      step(10);
      chk("t4_total", 64'(log_q.size()), 64'(base + 16));
      chk("t4_ovf_sticky", {63'd0, overflow}, 64'd1);
      chk("t4_idle_busy", {63'd0, busy}, 64'd0);

      // T6: reset during drain with rotations in flight
      issue(32'h3F80_0000, 32'h4000_0000);
      issue(32'h4040_0000, 32'h4080_0000);
      issue(32'h4100_0000, 32'h4110_0000);
      issue(32'h4120_0000, 32'h4130_0000);
      i = 0;
      while (!out_valid && i < 50) begin
         step(1);
         i++;
      end
      chk("t6_valid_seen", {63'd0, out_valid}, 64'd1);
      step(1);
      issue(32'h4200_0000, 32'h4210_0000);
      issue(32'h4220_0000, 32'h4230_0000);
      #2;
      clr = 1'b0;
      #1;
      chk("t6_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_last", {63'd0, out_last}, 64'd0);
      chk("t6_idx", {61'd0, out_idx}, 64'd0);
      chk("t6_data", {32'd0, out_data}, 64'd0);
      chk("t6_ovf", {63'd0, overflow}, 64'd0);
      chk("t6_busy", {63'd0, busy}, 64'd0);
      step(2);
      clr  = 1'b1;
      base = log_q.size();
      step(40);
      chk("t6_no_output", 64'(log_q.size()), 64'(base));
      chk("t6_end_busy", {63'd0, busy}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
